clg_serial_sub: RTL
===================

# clg_serial_sub

Multi-cycle WIDTH-bit subtractor that computes `a - b - borrow_in` one 4-bit nibble per clock. Each nibble uses a 4-bit carry-lookahead group: per-bit G/P over `a` and `~b`, a lookahead carry chain, and a registered group carry-out that chains into the next nibble. It is the subtract-side companion to the adder datapath. It sits behind a valid/ready request port and a valid/ready result port, so it can share operands with the adder tree while keeping per-cycle logic depth at one 4-bit group.

## Interface
Parameters:
- `WIDTH`, default 16, operand width. Must be a multiple of 4 and at least 4. N = WIDTH/4 nibbles.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start_valid`  in  1  request valid.
- `start_ready`  out  1  request ready. High only in IDLE.
- `a`  in  WIDTH  minuend. Sampled on accept.
- `b`  in  WIDTH  subtrahend. Sampled on accept.
- `borrow_in`  in  1  incoming borrow. Sampled on accept.
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  result consumed.
- `diff`  out  WIDTH  `a - b - borrow_in` mod 2^WIDTH.
- `borrow_out`  out  1  1 when unsigned `a < b + borrow_in`.
- `ovf`  out  1  signed overflow. Present only with `CLG_SUB_OVF_EN`.

## Operation
States: IDLE, RUN, DONE.

IDLE:
- `start_ready`=1.
- On `start_valid & start_ready`:
  - latch `a` and `~b`;
  - set carry register = `~borrow_in`;
  - set nibble index k=0;
  - go to RUN.

RUN, one nibble per cycle:
- For bits i=4k..4k+3: `G[i] = a[i] & ~b[i]`, `P[i] = a[i] ^ ~b[i]`.
- Lookahead carries: `C0` = carry register, `C[j+1] = G[j] | P[j]&C[j]`, evaluated as flat two-level AND-OR terms, not a ripple.
- Write `diff[4k+3:4k] = P ^ C[3:0]`.
- Update carry register with `C4`, then k=k+1.
- After the nibble at k=N-1, go to DONE.

DONE:
- `res_valid`=1.
- `borrow_out` = ~(final carry register).
- On `res_ready`, go to IDLE.

Stability and input rules:
- `diff`, `borrow_out` and `ovf` hold stable from DONE entry until the next accept.
- `a`, `b` and `borrow_in` are ignored outside the accept cycle.
- `start_valid` is ignored in RUN and DONE. No queuing; one operation is in flight at a time.

Reset:
- Async assertion of `rst_n` from any state forces IDLE and aborts any in-flight operation.
- An aborted operation produces no `res_valid`.
- Reset values: `start_ready`=1, `res_valid`=0, `diff`=0, `borrow_out`=0, `ovf`=0, k=0, carry register=0.

## Timing
- Accept at edge T. Nibble j is written at edge T+1+j. DONE is entered at edge T+N, so `res_valid` is high starting in cycle T+N (N cycles after accept).
- `res_valid & res_ready` at edge D: IDLE from D. `start_ready` is high in the next cycle, and the earliest next accept is edge D+1.
- Minimum throughput: one operation per N+2 cycles.
- `res_ready` held low: DONE holds indefinitely with outputs frozen.
- `res_ready` high already when DONE is entered: exactly one `res_valid` cycle.
- `start_ready` is decoded from state only. There is no combinational path from `start_valid` or `res_ready` to any output.
- k wraps to 0 on every accept. k never exceeds N-1.

## Configuration
- `CLG_SUB_OVF_EN` defined:
  - `ovf` port exists;
  - on DONE entry, `ovf` is set to `(a[W-1] != b[W-1]) & (diff[W-1] != a[W-1])`, using the latched operands;
  - `ovf` holds with `diff`.
- `CLG_SUB_OVF_EN` undefined: the `ovf` port and its register are absent. All other behaviour is identical.

## Test plan
All scenarios use WIDTH=16 (N=4).
- Basic: a=0x1234, b=0x0234, borrow_in=0 -> `diff`=0x1000, `borrow_out`=0, `res_valid` rises exactly 4 cycles after accept.
- Underflow: a=0x0000, b=0x0001 -> `diff`=0xFFFF, `borrow_out`=1, `ovf`=0.
- Borrow-in with carry through all nibbles: a=0x0005, b=0x0005, borrow_in=1 -> `diff`=0xFFFF, `borrow_out`=1.
- Signed overflow (macro on): a=0x8000, b=0x0001 -> `diff`=0x7FFF, `borrow_out`=0, `ovf`=1. Same stimulus with the macro off: no `ovf` port, same `diff` and `borrow_out`.
- Backpressure: hold `res_ready`=0 for 10 cycles while toggling `start_valid`, `a` and `b` -> `res_valid` stays 1, `diff` is unchanged, `start_ready`=0 and nothing is accepted. Release `res_ready` -> `start_ready`=1 in the next cycle.
- Reset mid-RUN: assert `rst_n`=0 after 2 nibbles -> immediately `res_valid`=0, `diff`=0, `start_ready`=1. After release, a fresh 0x1234-0x0234 yields 0x1000.

Source files
------------

// File: rtl/clg_serial_sub_if.sv
// Request/result handshake bundle for clg_serial_sub.
// The ovf signal exists only when CLG_SUB_OVF_EN is defined.
interface clg_serial_sub_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
`ifdef CLG_SUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start_valid, a, b, borrow_in, res_ready,
        input  start_ready, res_valid, diff, borrow_out
`ifdef CLG_SUB_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start_valid, a, b, borrow_in, res_ready,
        output start_ready, res_valid, diff, borrow_out
`ifdef CLG_SUB_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/clg_serial_sub.sv
// Nibble-serial a - b - borrow_in using one 4-bit carry-lookahead group per cycle.
// Optional signed-overflow flag enabled by defining CLG_SUB_OVF_EN.
module clg_serial_sub #(
    parameter int unsigned WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    clg_serial_sub_if.slave io_bus
);
    localparam int unsigned N  = WIDTH / 4;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_nxt_state;
    logic             w_accept;
    logic             w_last;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_nb;
    logic [WIDTH-1:0] r_diff;
    logic [KW-1:0]    r_k;
    logic             r_carry;
    logic             r_borrow_out;
    logic             r_start_ready;
    logic             r_res_valid;
`ifdef CLG_SUB_OVF_EN
    logic             r_ovf;
`endif

    logic [3:0]       w_a_nib;
    logic [3:0]       w_nb_nib;
    logic [3:0]       w_g;
    logic [3:0]       w_p;
    logic [4:0]       w_c;
    logic [3:0]       w_sum;

    // Select the active nibble of the latched operands.
    always_comb begin
        w_a_nib  = '0;
        w_nb_nib = '0;
        for (int n = 0; n < int'(N); n++) begin
            if (r_k == KW'(n)) begin
                w_a_nib  = r_a[n*4 +: 4];
                w_nb_nib = r_nb[n*4 +: 4];
            end
        end
    end

    // Flat two-level lookahead; no ripple between bit positions.
    always_comb begin
        w_g    = w_a_nib & w_nb_nib;
        w_p    = w_a_nib ^ w_nb_nib;
        w_c[0] = r_carry;
        w_c[1] = w_g[0] | (w_p[0] & r_carry);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_carry);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & r_carry);
        w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_carry);
        w_sum  = w_p ^ w_c[3:0];
    end

    assign w_last = (r_k == KW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (io_bus.start_valid) begin
                    w_accept    = 1'b1;
                    w_nxt_state = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_nxt_state = S_DONE;
                end
            end
            S_DONE: begin
                if (io_bus.res_ready) begin
                    w_nxt_state = S_IDLE;
                end
            end
            default: w_nxt_state = S_IDLE;
        endcase
    end

    // Handshake flags are registered copies of the next-state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_ready <= 1'b1;
            r_res_valid   <= 1'b0;
        end else begin
            r_start_ready <= (w_nxt_state == S_IDLE);
            r_res_valid   <= (w_nxt_state == S_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a          <= '0;
            r_nb         <= '0;
            r_diff       <= '0;
            r_k          <= '0;
            r_carry      <= 1'b0;
            r_borrow_out <= 1'b0;
`ifdef CLG_SUB_OVF_EN
            r_ovf        <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a     <= io_bus.a;
            r_nb    <= ~io_bus.b;
            r_carry <= ~io_bus.borrow_in;
            r_k     <= '0;
        end else if (r_state == S_RUN) begin
            r_carry <= w_c[4];
            for (int n = 0; n < int'(N); n++) begin
                if (r_k == KW'(n)) begin
                    r_diff[n*4 +: 4] <= w_sum;
                end
            end
            if (w_last) begin
                r_borrow_out <= ~w_c[4];
`ifdef CLG_SUB_OVF_EN
                // a and b differ in sign when a matches the inverted b.
                r_ovf <= (r_a[WIDTH-1] == r_nb[WIDTH-1]) & (w_sum[3] != r_a[WIDTH-1]);
`endif
            end else begin
                r_k <= r_k + KW'(1);
            end
        end
    end

    assign io_bus.start_ready = r_start_ready;
    assign io_bus.res_valid   = r_res_valid;
    assign io_bus.diff        = r_diff;
    assign io_bus.borrow_out  = r_borrow_out;
`ifdef CLG_SUB_OVF_EN
    assign io_bus.ovf         = r_ovf;
`endif
endmodule
